// File: rtl/bist_pkg.sv
// bist_pkg: shared types and constants for the March C- BIST controller.
package bist_pkg;
  typedef enum logic [2:0] {IDLE, INIT, WO, RD, WR, RO, FLUSH, DONE} state_e;
  typedef enum logic [1:0] {OP_WO, OP_RW, OP_RO} op_kind_e;
  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;
  localparam int NUM_ELEM = 6;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  localparam logic BG0 = 1'b0;
  localparam logic BG1 = 1'b1;
endpackage

// File: rtl/march_element_rom.sv
// march_element_rom: per-element direction, op kind and data backgrounds for March C-.
module march_element_rom import bist_pkg::*; #(
  parameter int D_WIDTH = 8
) (
  input  logic [2:0]         elem_i,
  output logic               up_o,
  output op_kind_e           op_o,
  output logic [D_WIDTH-1:0] rexp_o,
  output logic [D_WIDTH-1:0] wdata_o
);
  always_comb begin
    up_o    = (elem_i == E3 || elem_i == E4) ? DIR_DN : DIR_UP;
    op_o    = (elem_i == E0) ? OP_WO : (elem_i == E5) ? OP_RO : OP_RW;
    rexp_o  = {D_WIDTH{(elem_i == E2 || elem_i == E4) ? BG1 : BG0}};
    wdata_o = {D_WIDTH{(elem_i == E1 || elem_i == E3) ? BG1 : BG0}};
  end
endmodule

// File: rtl/march_controller.sv
// march_controller: March C- sequencer driving an external address counter, with a
// one-cycle registered compare stage and sticky first-failure status.
module march_controller import bist_pkg::*; #(
  parameter int A_WIDTH = 4,
  parameter int D_WIDTH = 8,
  parameter int ERR_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [A_WIDTH-1:0] ag_addr,
  output logic               ag_clr,
  output logic               ag_preset,
  output logic               ag_en,
  output logic               ag_up,
  output logic               mem_we,
  output logic               mem_re,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [A_WIDTH-1:0] fail_addr,
  output logic [2:0]         fail_elem,
  output logic [ERR_W-1:0]   err_count
);
  state_e state_q, state_d;
  logic [2:0] elem_q, elem_d;
  logic dir_up, cap, terminal, go, miss;
  op_kind_e op;
  logic [D_WIDTH-1:0] rexp, wbg;
  logic pend_q;
  logic [D_WIDTH-1:0] exp_q;
  logic [A_WIDTH-1:0] addr_q, fail_addr_q;
  logic [2:0] pelem_q, fail_elem_q;
  logic fail_q;
  logic [ERR_W-1:0] err_q;

  march_element_rom #(.D_WIDTH(D_WIDTH)) u_rom (
    .elem_i  (elem_q),
    .up_o    (dir_up),
    .op_o    (op),
    .rexp_o  (rexp),
    .wdata_o (wbg)
  );

  assign terminal = dir_up ? &ag_addr : ~|ag_addr;
  assign busy     = state_q != IDLE && state_q != DONE;
  assign done     = state_q == DONE;
  assign go       = start && !busy;
  assign miss     = pend_q && mem_rdata != exp_q;

  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    ag_clr    = 1'b0;
    ag_preset = 1'b0;
    ag_en     = 1'b0;
    ag_up     = busy && dir_up;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    cap       = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = go ? INIT : state_q;
        elem_d  = go ? E0 : elem_q;
      end
      INIT: begin
        ag_clr    = dir_up;
        ag_preset = !dir_up;
        state_d   = op == OP_WO ? WO : op == OP_RW ? RD : RO;
      end
      RD: begin
        mem_re  = 1'b1;
        cap     = 1'b1;
        state_d = WR;
      end
      WO, WR: begin
        mem_we    = 1'b1;
        mem_wdata = wbg;
        ag_en     = 1'b1;
        state_d   = !terminal ? (state_q == WR ? RD : WO) : INIT;
        elem_d    = terminal ? elem_q + 3'd1 : elem_q;
      end
      RO: begin
        mem_re  = 1'b1;
        ag_en   = 1'b1;
        cap     = 1'b1;
        state_d = terminal ? FLUSH : RO;
      end
      FLUSH: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      elem_q      <= E0;
      pend_q      <= 1'b0;
      exp_q       <= '0;
      addr_q      <= '0;
      pelem_q     <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      err_q       <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      pend_q  <= cap;
      if (cap) begin
        exp_q   <= rexp;
        addr_q  <= ag_addr;
        pelem_q <= elem_q;
      end
      if (go) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_elem_q <= '0;
        err_q       <= '0;
      end else if (miss) begin
        err_q <= &err_q ? err_q : err_q + 1'b1;
        if (!fail_q) begin
          fail_q      <= 1'b1;
          fail_addr_q <= addr_q;
          fail_elem_q <= pelem_q;
        end
      end
    end
  end

  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign err_count = err_q;
endmodule

// File: tb/tb_march_controller.sv
// tb_march_controller: directed checks of the March C- controller against a behavioural
// address counter and a byte-wide memory with an injectable stuck-at fault.
module tb_march_controller;
  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] ag_addr;
  logic       ag_clr, ag_preset, ag_en, ag_up, mem_we, mem_re;
  logic [7:0] mem_wdata, mem_rdata;
  logic       busy, done, fail;
  logic [3:0] fail_addr;
  logic [2:0] fail_elem;
  logic [7:0] err_count;
  logic [7:0] mem [16];
  logic [3:0] f_addr;
  logic [7:0] f_or, f_and;
  int checks = 0, passed = 0, viol = 0;

  always #5 clk = ~clk;

  march_controller #(.A_WIDTH(4), .D_WIDTH(8), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .ag_addr(ag_addr),
    .ag_clr(ag_clr), .ag_preset(ag_preset), .ag_en(ag_en), .ag_up(ag_up),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_elem(fail_elem), .err_count(err_count)
  );

  always @(posedge clk) begin
    if (reset) ag_addr <= '0;
    else if (ag_clr) ag_addr <= '0;
    else if (ag_preset) ag_addr <= '1;
    else if (ag_en) ag_addr <= ag_up ? ag_addr + 4'd1 : ag_addr - 4'd1;
  end

  always @(posedge clk) begin
    if (mem_we) mem[ag_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= (ag_addr == f_addr) ? ((mem[ag_addr] | f_or) & f_and) : mem[ag_addr];
  end

  always @(negedge clk)
    if ((mem_we && mem_re) || (int'(ag_clr) + int'(ag_preset) + int'(ag_en) > 1)) viol++;

  task automatic run(input int pulse_at, output int n);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      start = (n == pulse_at);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  task automatic no_fault();
    f_addr = 4'd0; f_or = 8'h00; f_and = 8'hFF;
  endtask

  task automatic check_ok_run(input string tag, input int n);
    checks++; if (n !== 167) $display("FAIL %s busy_cycles got %0d want 167", tag, n); else passed++;
    checks++; if (done !== 1'b1) $display("FAIL %s done got %b want 1", tag, done); else passed++;
    checks++; if (fail !== 1'b0) $display("FAIL %s fail got %b want 0", tag, fail); else passed++;
    checks++; if (err_count !== 8'd0) $display("FAIL %s err_count got %0d want 0", tag, err_count); else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, fail, fail_addr, fail_elem, err_count, ag_clr, ag_preset, ag_en, ag_up,
         mem_we, mem_re, mem_wdata} !== '0)
      $display("FAIL reset_outputs busy=%b done=%b fail=%b err=%0d we=%b re=%b want all 0",
               busy, done, fail, err_count, mem_we, mem_re);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_fault_free();
    int n;
    no_fault();
    run(-1, n);
    check_ok_run("fault_free", n);
  endtask

  task automatic test_stuck(input string tag, input logic [3:0] a, input logic [7:0] o,
                            input logic [7:0] m, input logic [2:0] e, input logic [7:0] ec);
    int n;
    f_addr = a; f_or = o; f_and = m;
    run(-1, n);
    checks++; if (n !== 167) $display("FAIL %s busy_cycles got %0d want 167", tag, n); else passed++;
    checks++; if (fail !== 1'b1) $display("FAIL %s fail got %b want 1", tag, fail); else passed++;
    checks++; if (fail_addr !== a) $display("FAIL %s fail_addr got %0d want %0d", tag, fail_addr, a); else passed++;
    checks++; if (fail_elem !== e) $display("FAIL %s fail_elem got %0d want %0d", tag, fail_elem, e); else passed++;
    checks++; if (err_count !== ec) $display("FAIL %s err_count got %0d want %0d", tag, err_count, ec); else passed++;
  endtask

  task automatic test_addr_seq();
    int k;
    no_fault();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    // k counts busy cycles; E3 INIT is cycle 17 + 2*33 = 83
    for (k = 0; k < 170 && busy === 1'b1; k++) begin
      if (k == 0) begin
        checks++; if ({ag_clr, ag_preset, ag_up} !== 3'b101) $display("FAIL e0_init clr/preset/up got %b want 101", {ag_clr, ag_preset, ag_up}); else passed++;
      end
      if (k == 83) begin
        checks++; if ({ag_clr, ag_preset, ag_up} !== 3'b010) $display("FAIL e3_init clr/preset/up got %b want 010", {ag_clr, ag_preset, ag_up}); else passed++;
      end
      if (k == 84) begin
        checks++; if ({mem_re, ag_addr} !== 5'h1F) $display("FAIL e3_first_rd re=%b addr=%0d want re=1 addr=15", mem_re, ag_addr); else passed++;
      end
      if (k == 115) begin
        checks++; if ({mem_we, ag_addr} !== 5'h10) $display("FAIL e3_last_wr we=%b addr=%0d want we=1 addr=0", mem_we, ag_addr); else passed++;
      end
      if (k == 116) begin
        checks++; if ({ag_preset, ag_up, mem_we, mem_re} !== 4'b1000) $display("FAIL e4_init preset/up/we/re got %b want 1000", {ag_preset, ag_up, mem_we, mem_re}); else passed++;
      end
      @(negedge clk);
    end
    checks++; if (k !== 167) $display("FAIL addr_seq busy_cycles got %0d want 167", k); else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    no_fault();
    f_addr = 4'd3; f_or = 8'h10; f_and = 8'hFF;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (60) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, fail, fail_addr, fail_elem, err_count, ag_clr, ag_preset, ag_en, ag_up,
         mem_we, mem_re, mem_wdata} !== '0)
      $display("FAIL reset_mid_outputs busy=%b fail=%b err=%0d we=%b re=%b want all 0",
               busy, fail, err_count, mem_we, mem_re);
    else passed++;
    reset = 1'b0;
    no_fault();
    run(-1, n);
    check_ok_run("after_reset", n);
  endtask

  task automatic test_start_busy();
    int n;
    no_fault();
    run(40, n);
    check_ok_run("start_busy", n);
  endtask

  task automatic test_restart_after_fail();
    int n;
    f_addr = 4'd5; f_or = 8'h01; f_and = 8'hFF;
    run(-1, n);
    checks++; if (fail !== 1'b1) $display("FAIL pre_restart fail got %b want 1", fail); else passed++;
    no_fault();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if ({busy, done, fail, err_count} !== {1'b1, 1'b0, 1'b0, 8'd0})
      $display("FAIL restart_clear busy=%b done=%b fail=%b err=%0d want 1 0 0 0", busy, done, fail, err_count);
    else passed++;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_ok_run("restart", n + 0);
  endtask

  task automatic test_exclusive();
    checks++; if (viol !== 0) $display("FAIL strobe_exclusive violations got %0d want 0", viol); else passed++;
  endtask

  initial begin
    no_fault();
    test_reset();
    test_fault_free();
    test_stuck("sa1_a5_b0", 4'd5, 8'h01, 8'hFF, 3'd1, 8'd3);
    test_stuck("sa0_a15_b7", 4'd15, 8'h00, 8'h7F, 3'd2, 8'd2);
    test_addr_seq();
    test_reset_mid();
    test_start_busy();
    test_restart_after_fail();
    test_exclusive();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
